// File: rtl/irq_entry_sequencer_pkg.sv
// Shared types and constants for the IRQ entry/return sequencer.
package irq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_SAVE,
    ST_VECTOR,
    ST_ACK,
    ST_HANDLER,
    ST_RESTORE
  } irq_state_e;

  localparam logic [4:0] MODE_IRQ = 5'b10010;

  localparam logic [1:0] PC_S_SEQ = 2'b00;
  localparam logic [1:0] PC_S_RET = 2'b10;
  localparam logic [1:0] PC_S_VEC = 2'b11;

  localparam int CPSR_I_BIT = 7;
  localparam int CPSR_F_BIT = 6;
  localparam int CPSR_T_BIT = 5;

  // IRQ entry keeps flags and F, sets I, forces ARM state and IRQ mode.
  function automatic logic [31:0] irq_entry_cpsr(input logic [31:0] cpsr);
    return {cpsr[31:CPSR_I_BIT+1], 1'b1, cpsr[CPSR_F_BIT], 1'b0, MODE_IRQ};
  endfunction

endpackage

// File: rtl/irq_entry_sequencer_latency_counter.sv
// Entry latency counter: counts cycles while counting is high, captures
// count+1 on the final counted cycle, saturates at 16'hFFFF.
module irq_latency_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_counting,
  input  logic        i_capture,
  output logic [15:0] o_latency
);

  logic [15:0] r_count;
  logic [15:0] r_latency;
  logic [15:0] w_count_inc;

  assign w_count_inc = (r_count == 16'hFFFF) ? 16'hFFFF : r_count + 16'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count   <= 16'd0;
      r_latency <= 16'd0;
    end else begin
      if (!i_counting) begin
        r_count <= 16'd0;
      end else begin
        r_count <= w_count_inc;
      end
      if (i_capture) begin
        r_latency <= w_count_inc;
      end
    end
  end

  assign o_latency = r_latency;

endmodule

// File: rtl/irq_entry_sequencer.sv
// ARMv7 IRQ exception entry/return sequencer (Moore FSM).
// Optional entry-latency statistics under IRQ_LATENCY_STATS_EN.
module irq_entry_sequencer
  import irq_pkg::*;
#(
  parameter logic [31:0] VECTOR_ADDR = 32'h0000_0018
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        int_irq,
  input  logic        instr_done,
  input  logic        exc_return,
  input  logic [31:0] cpsr_in,
  input  logic [31:0] spsr_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] lr_in,
  output logic        stall,
  output logic        inta_irq,
  output logic [1:0]  pc_s,
  output logic        write_pc,
  output logic [31:0] pc_wdata,
  output logic        lr_we,
  output logic        spsr_we,
  output logic        cpsr_we,
  output logic [31:0] lr_wdata,
  output logic [31:0] spsr_wdata,
  output logic [31:0] cpsr_wdata,
  output logic        in_isr
`ifdef IRQ_LATENCY_STATS_EN
  ,
  output logic [15:0] irq_latency
`endif
);

  irq_state_e r_state;
  irq_state_e w_state_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    stall        = 1'b0;
    inta_irq     = 1'b0;
    pc_s         = PC_S_SEQ;
    write_pc     = 1'b0;
    pc_wdata     = 32'd0;
    lr_we        = 1'b0;
    spsr_we      = 1'b0;
    cpsr_we      = 1'b0;
    lr_wdata     = 32'd0;
    spsr_wdata   = 32'd0;
    cpsr_wdata   = 32'd0;
    in_isr       = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (int_irq && !cpsr_in[CPSR_I_BIT]) w_state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        stall = 1'b1;
        // Retirement wins over a request withdrawn in the same cycle.
        if (instr_done)    w_state_next = ST_SAVE;
        else if (!int_irq) w_state_next = ST_IDLE;
      end
      ST_SAVE: begin
        stall        = 1'b1;
        lr_we        = 1'b1;
        lr_wdata     = pc_in + 32'd4;
        spsr_we      = 1'b1;
        spsr_wdata   = cpsr_in;
        w_state_next = ST_VECTOR;
      end
      ST_VECTOR: begin
        stall        = 1'b1;
        write_pc     = 1'b1;
        pc_s         = PC_S_VEC;
        pc_wdata     = VECTOR_ADDR;
        cpsr_we      = 1'b1;
        cpsr_wdata   = irq_entry_cpsr(cpsr_in);
        w_state_next = ST_ACK;
      end
      ST_ACK: begin
        inta_irq     = 1'b1;
        w_state_next = ST_HANDLER;
      end
      ST_HANDLER: begin
        in_isr = 1'b1;
        if (exc_return) w_state_next = ST_RESTORE;
      end
      ST_RESTORE: begin
        in_isr       = 1'b1;
        write_pc     = 1'b1;
        pc_s         = PC_S_RET;
        pc_wdata     = lr_in - 32'd4;
        cpsr_we      = 1'b1;
        cpsr_wdata   = spsr_in;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

`ifdef IRQ_LATENCY_STATS_EN
  logic w_lat_counting;
  logic w_lat_capture;

  assign w_lat_counting = (r_state == ST_DRAIN) || (r_state == ST_SAVE) ||
                          (r_state == ST_VECTOR);
  assign w_lat_capture  = (r_state == ST_VECTOR);

  irq_latency_counter u_latency (
    .clk        (clk),
    .rst        (rst),
    .i_counting (w_lat_counting),
    .i_capture  (w_lat_capture),
    .o_latency  (irq_latency)
  );
`endif

endmodule

// File: tb/tb_irq_entry_sequencer.sv
// Scoreboard bench: stimulus pushes expected bank/PC write transactions,
// a negedge monitor pops and compares whenever a write or ack is presented.
module tb_irq_entry_sequencer;

  logic        clk;
  logic        rst;
  logic        int_irq;
  logic        instr_done;
  logic        exc_return;
  logic [31:0] cpsr_in;
  logic [31:0] spsr_in;
  logic [31:0] pc_in;
  logic [31:0] lr_in;
  logic        stall;
  logic        inta_irq;
  logic [1:0]  pc_s;
  logic        write_pc;
  logic [31:0] pc_wdata;
  logic        lr_we;
  logic        spsr_we;
  logic        cpsr_we;
  logic [31:0] lr_wdata;
  logic [31:0] spsr_wdata;
  logic [31:0] cpsr_wdata;
  logic        in_isr;
`ifdef IRQ_LATENCY_STATS_EN
  logic [15:0] irq_latency;
`endif

  int checks = 0;
  int errors = 0;

  irq_entry_sequencer #(.VECTOR_ADDR(32'h0000_0018)) dut (
    .clk        (clk),
    .rst        (rst),
    .int_irq    (int_irq),
    .instr_done (instr_done),
    .exc_return (exc_return),
    .cpsr_in    (cpsr_in),
    .spsr_in    (spsr_in),
    .pc_in      (pc_in),
    .lr_in      (lr_in),
    .stall      (stall),
    .inta_irq   (inta_irq),
    .pc_s       (pc_s),
    .write_pc   (write_pc),
    .pc_wdata   (pc_wdata),
    .lr_we      (lr_we),
    .spsr_we    (spsr_we),
    .cpsr_we    (cpsr_we),
    .lr_wdata   (lr_wdata),
    .spsr_wdata (spsr_wdata),
    .cpsr_wdata (cpsr_wdata),
    .in_isr     (in_isr)
`ifdef IRQ_LATENCY_STATS_EN
    ,
    .irq_latency(irq_latency)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        stall;
    logic        inta;
    logic        write_pc;
    logic [1:0]  pc_s;
    logic        lr_we;
    logic        spsr_we;
    logic        cpsr_we;
    logic        in_isr;
    logic [31:0] pc_wdata;
    logic [31:0] lr_wdata;
    logic [31:0] spsr_wdata;
    logic [31:0] cpsr_wdata;
  } obs_t;

  obs_t  exp_q[$];
  string name_q[$];

  function automatic obs_t mk(input logic st, input logic ia, input logic wp,
                              input logic [1:0] ps, input logic lw, input logic sw,
                              input logic cw, input logic isr, input logic [31:0] pcd,
                              input logic [31:0] lrd, input logic [31:0] spd,
                              input logic [31:0] cpd);
    obs_t o;
    o.stall = st; o.inta = ia; o.write_pc = wp; o.pc_s = ps;
    o.lr_we = lw; o.spsr_we = sw; o.cpsr_we = cw; o.in_isr = isr;
    o.pc_wdata = pcd; o.lr_wdata = lrd; o.spsr_wdata = spd; o.cpsr_wdata = cpd;
    return o;
  endfunction

  // Data fields are only meaningful when their write enable is asserted.
  function automatic bit obs_match(input obs_t a, input obs_t e);
    bit ok;
    ok = (a.stall == e.stall) && (a.inta == e.inta) && (a.write_pc == e.write_pc) &&
         (a.pc_s == e.pc_s) && (a.lr_we == e.lr_we) && (a.spsr_we == e.spsr_we) &&
         (a.cpsr_we == e.cpsr_we) && (a.in_isr == e.in_isr);
    if (e.write_pc && a.pc_wdata !== e.pc_wdata)   ok = 0;
    if (e.lr_we    && a.lr_wdata !== e.lr_wdata)   ok = 0;
    if (e.spsr_we  && a.spsr_wdata !== e.spsr_wdata) ok = 0;
    if (e.cpsr_we  && a.cpsr_wdata !== e.cpsr_wdata) ok = 0;
    return ok;
  endfunction

  always @(negedge clk) begin
    obs_t  a;
    obs_t  e;
    string nm;
    if (!rst && (lr_we || spsr_we || cpsr_we || write_pc || inta_irq)) begin
      a = mk(stall, inta_irq, write_pc, pc_s, lr_we, spsr_we, cpsr_we, in_isr,
             pc_wdata, lr_wdata, spsr_wdata, cpsr_wdata);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_txn got ctl=%b pc=%h lr=%h spsr=%h cpsr=%h required none",
                 {a.stall, a.inta, a.write_pc, a.pc_s, a.lr_we, a.spsr_we, a.cpsr_we, a.in_isr},
                 a.pc_wdata, a.lr_wdata, a.spsr_wdata, a.cpsr_wdata);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (!obs_match(a, e)) begin
          errors++;
          $display("FAIL %s got ctl=%b pc=%h lr=%h spsr=%h cpsr=%h required ctl=%b pc=%h lr=%h spsr=%h cpsr=%h",
                   nm,
                   {a.stall, a.inta, a.write_pc, a.pc_s, a.lr_we, a.spsr_we, a.cpsr_we, a.in_isr},
                   a.pc_wdata, a.lr_wdata, a.spsr_wdata, a.cpsr_wdata,
                   {e.stall, e.inta, e.write_pc, e.pc_s, e.lr_we, e.spsr_we, e.cpsr_we, e.in_isr},
                   e.pc_wdata, e.lr_wdata, e.spsr_wdata, e.cpsr_wdata);
        end else begin
          $display("txn %s ok ctl=%b pc=%h lr=%h spsr=%h cpsr=%h", nm,
                   {a.stall, a.inta, a.write_pc, a.pc_s, a.lr_we, a.spsr_we, a.cpsr_we, a.in_isr},
                   a.pc_wdata, a.lr_wdata, a.spsr_wdata, a.cpsr_wdata);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%h required=%h", nm, got, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] out_summary();
    return {stall, inta_irq, write_pc, lr_we, spsr_we, cpsr_we, in_isr, pc_s,
            |pc_wdata, |(lr_wdata | spsr_wdata | cpsr_wdata)};
  endfunction

  task automatic expect_txn(input string nm, input obs_t o);
    exp_q.push_back(o);
    name_q.push_back(nm);
  endtask

  // Leaves the bench in HANDLER, or in VECTOR when abort_in_vector is set.
  task automatic run_entry(input logic [31:0] cpsr, input logic [31:0] pc,
                           input int drain, input bit abort_in_vector);
    logic [31:0] cpsr_irq;
    cpsr_irq = {cpsr[31:8], 1'b1, cpsr[6], 1'b0, 5'b10010};
    cpsr_in = cpsr;
    pc_in   = pc;
    expect_txn("save", mk(1, 0, 0, 2'b00, 1, 1, 0, 0, 32'h0, pc + 32'd4, cpsr, 32'h0));
    expect_txn("vector", mk(1, 0, 1, 2'b11, 0, 0, 1, 0, 32'h18, 32'h0, 32'h0, cpsr_irq));
    if (!abort_in_vector) expect_txn("ack", mk(0, 1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
    int_irq    = 1'b1;
    instr_done = 1'b0;
    step();
    for (int i = 1; i < drain; i++) begin
      chk("drain_stall", {63'd0, stall}, 64'd1);
      step();
    end
    chk("drain_stall", {63'd0, stall}, 64'd1);
    instr_done = 1'b1;
    step();
    instr_done = 1'b0;
    step();
    if (abort_in_vector) return;
    step();
    chk("ack_cycle", {63'd0, inta_irq}, 64'd1);
    int_irq = 1'b0;
    step();
    chk("handler_isr_stall", {62'd0, in_isr, stall}, 64'd2);
    chk("ack_single_pulse", {63'd0, inta_irq}, 64'd0);
  endtask

  task automatic run_return(input logic [31:0] lr, input logic [31:0] spsr);
    lr_in   = lr;
    spsr_in = spsr;
    expect_txn("restore", mk(0, 0, 1, 2'b10, 0, 0, 1, 1, lr - 32'd4, 0, 0, spsr));
    exc_return = 1'b1;
    step();
    exc_return = 1'b0;
    step();
    chk("idle_after_restore", {53'd0, out_summary()}, 64'd0);
  endtask

  initial begin
    rst = 1'b1; int_irq = 0; instr_done = 0; exc_return = 0;
    cpsr_in = 0; spsr_in = 0; pc_in = 0; lr_in = 0;
    #1;
    chk("reset_outputs", {53'd0, out_summary()}, 64'd0);
    step();
    step();
    rst = 1'b0;
    step();
    chk("idle_outputs", {53'd0, out_summary()}, 64'd0);

    // Minimum-latency entry and return.
    run_entry(32'h0000_0010, 32'h0000_0100, 1, 0);
`ifdef IRQ_LATENCY_STATS_EN
    chk("latency_min", {48'd0, irq_latency}, 64'd3);
`endif
    step();
    chk("handler_hold", {63'd0, in_isr}, 64'd1);
    run_return(32'h0000_0104, 32'h0000_0010);

    // Exception return outside HANDLER must do nothing.
    exc_return = 1'b1;
    step();
    exc_return = 1'b0;
    step();
    chk("stray_exc_return", {53'd0, out_summary()}, 64'd0);

    // Masked request.
    cpsr_in = 32'h0000_0090;
    int_irq = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i % 5 == 4) chk("masked_idle", {53'd0, out_summary()}, 64'd0);
    end
    int_irq = 1'b0;

    // Drain then withdrawal.
    cpsr_in    = 32'h0000_0010;
    int_irq    = 1'b1;
    instr_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("withdraw_drain_stall", {63'd0, stall}, 64'd1);
    end
    int_irq = 1'b0;
    step();
    chk("withdraw_idle", {53'd0, out_summary()}, 64'd0);
    step();
    chk("withdraw_stays_idle", {53'd0, out_summary()}, 64'd0);

    // Two-cycle drain, different CPSR flags and F bit.
    run_entry(32'hA000_0053, 32'h0000_2000, 2, 0);
`ifdef IRQ_LATENCY_STATS_EN
    chk("latency_drain2", {48'd0, irq_latency}, 64'd4);
`endif
    run_return(32'h0000_2004, 32'hA000_0053);

    // Reset during VECTOR.
    run_entry(32'h0000_0010, 32'h0000_0300, 1, 1);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("reset_mid_outputs", {53'd0, out_summary()}, 64'd0);
    int_irq = 1'b0;
    step();
    rst = 1'b0;
    step();
    chk("post_reset_idle", {53'd0, out_summary()}, 64'd0);
    step();
    chk("post_reset_no_stall", {63'd0, stall}, 64'd0);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/irq_entry_sequencer.md
# irq_entry_sequencer

Sequencer that turns the latched IRQ request into a complete ARMv7 IRQ exception entry and return. It waits for an instruction boundary, then banks LR/SPSR, redirects the PC to the IRQ vector, switches CPSR to IRQ mode with I set, and acknowledges the request. It later restores CPSR and PC on exception return. It sits between the interrupt request flops and the PC mux, register file, and CPSR/SPSR registers of the CPU datapath.

## Interface
Parameters:
- VECTOR_ADDR, 32'h0000_0018, IRQ vector address driven on pc_wdata during vectoring.

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-high reset
- int_irq  in  1  latched IRQ request (level)
- instr_done  in  1  current instruction retires this cycle
- exc_return  in  1  one-cycle pulse: SUBS PC, LR, #4 decoded in handler
- cpsr_in  in  32  current CPSR
- spsr_in  in  32  current SPSR_irq
- pc_in  in  32  address of next instruction to execute
- lr_in  in  32  current LR_irq
- stall  out  1  freeze fetch/issue
- inta_irq  out  1  acknowledge pulse; clears request flops
- pc_s  out  2  PC source: 00 sequential, 10 return, 11 vector
- write_pc  out  1  PC write enable
- pc_wdata  out  32  PC value for pc_s 10/11
- lr_we / spsr_we / cpsr_we  out  1 each  bank write enables
- lr_wdata, spsr_wdata, cpsr_wdata  out  32 each  write data
- in_isr  out  1  handler active

## Operation
States: IDLE, DRAIN, SAVE, VECTOR, ACK, HANDLER, RESTORE.
- IDLE: all outputs 0. If int_irq && !cpsr_in[7], go to DRAIN.
- DRAIN: stall=1. If instr_done, go to SAVE. Else if !int_irq (request withdrawn), go to IDLE. instr_done has priority over withdrawal.
- SAVE: stall=1, lr_we=1, lr_wdata=pc_in+4 (mod 2^32), spsr_we=1, spsr_wdata=cpsr_in. Next state VECTOR.
- VECTOR: stall=1, write_pc=1, pc_s=11, pc_wdata=VECTOR_ADDR, cpsr_we=1, cpsr_wdata={cpsr_in[31:8],1'b1,cpsr_in[6],1'b0,5'b10010}. Next state ACK.
- ACK: inta_irq=1, stall=0. Next state HANDLER.
- HANDLER: in_isr=1. On exc_return, go to RESTORE. int_irq is ignored.
- RESTORE: write_pc=1, pc_s=10, pc_wdata=lr_in-4 (mod 2^32), cpsr_we=1, cpsr_wdata=spsr_in, in_isr=1. Next state IDLE.
- exc_return outside HANDLER is ignored.

## Timing
- Reset: state IDLE; every output 0, including pc_s=00. Reset mid-sequence abandons the entry; no further bank writes occur.
- Minimum latency from int_irq at a boundary: DRAIN 1 cycle, then SAVE, VECTOR, ACK, so inta_irq is asserted 4 cycles after int_irq is sampled.
- Each of SAVE, VECTOR, ACK and RESTORE lasts exactly 1 cycle; every write enable is a single-cycle pulse.
- An int_irq still pending after RESTORE is re-evaluated in IDLE against the restored cpsr_in[7] on the following cycle.
- All outputs are registered-state decoded (Moore); none depends combinationally on int_irq.

## Configuration
- IRQ_LATENCY_STATS_EN defined:
  - Adds output irq_latency[15:0], the cycle count from entry to DRAIN through VECTOR inclusive.
  - It is captured when leaving VECTOR and holds until the next capture.
  - The counter saturates at 16'hFFFF.
  - Reset value is 0.
- IRQ_LATENCY_STATS_EN undefined: the port and counter are absent; behaviour is otherwise identical.

## Structure
- Shared package irq_pkg holds:
  - the state enum;
  - MODE_IRQ = 5'b10010;
  - the PC_S_SEQ/PC_S_RET/PC_S_VEC encodings;
  - the CPSR bit indices (I=7, F=6, T=5).
- One sub-module, irq_latency_counter, is instantiated only under IRQ_LATENCY_STATS_EN.

## Test plan
- Entry path: cpsr_in=32'h0000_0010, pc_in=32'h100, int_irq=1 with instr_done=1 in DRAIN.
  - Required: lr_wdata=32'h104 and spsr_wdata=32'h10 in SAVE.
  - Required: pc_wdata=32'h18 and cpsr_wdata=32'h0000_0092 in VECTOR.
  - Required: inta_irq pulses for 1 cycle in ACK.
- Masked request: cpsr_in[7]=1, int_irq=1 for 20 cycles -> state stays IDLE, stall=0, no write enables.
- Drain and withdrawal: instr_done held low 3 cycles -> stall=1 for 3 cycles. Then int_irq drops with instr_done=0 -> return to IDLE with no writes.
- Return path: in HANDLER, lr_in=32'h104, spsr_in=32'h10, exc_return pulse -> RESTORE with pc_s=10, pc_wdata=32'h100, cpsr_wdata=32'h10. Then IDLE.
- Reset mid-sequence: assert rst during VECTOR -> all outputs 0 immediately; after release, state is IDLE.
- Latency stats (with IRQ_LATENCY_STATS_EN): 2-cycle drain -> irq_latency=4.
